// File: rtl/meta_out_dispatch.sv
// meta_out_dispatch: buffers ALU-stage metadata in a small FIFO and offers it downstream
// through a registered valid/ready output stage. Optional feature macro: META_DISCARD_FILTER_EN.
module meta_out_dispatch #(
    parameter int META_LEN   = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int STAGE_ID   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [META_LEN-1:0]         comp_meta_data_in,
    input  logic                        comp_meta_data_valid_in,
    output logic [META_LEN-1:0]         meta_out,
    output logic                        meta_valid_out,
    input  logic                        meta_ready_in,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 ovf_cnt,
    output logic [15:0]                 drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if ((META_LEN != 256) || (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        || (STAGE_ID < 0)) begin : g_bad_params
        $error("meta_out_dispatch: unsupported parameter set");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [META_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [META_LEN-1:0] meta_q, meta_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                discard_s, pop_s, wr_en_s, lost_s;

`ifdef META_DISCARD_FILTER_EN
    assign discard_s = comp_meta_data_in[128];
`else
    assign discard_s = 1'b0;
`endif

    // Output FSM: decides when the head entry moves into the output register
    always_comb begin
        pop_s   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (level_q != {LW{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (meta_ready_in) begin
                    if (level_q != {LW{1'b0}}) begin
                        pop_s   = 1'b1;
                        state_d = ST_VALID;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: begin
                pop_s   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write acceptance, pointer/level bookkeeping and output register load
    always_comb begin
        wr_en_s = 1'b0;
        lost_s  = 1'b0;
        if (comp_meta_data_valid_in && !discard_s) begin
            // A full FIFO still accepts when the head leaves on the same edge
            if ((level_q < LW'(FIFO_DEPTH)) || pop_s) begin
                wr_en_s = 1'b1;
            end else begin
                lost_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
            lost_s  = 1'b0;
        end

        wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase

        meta_d = pop_s ? mem_q[rd_ptr_q] : meta_q;
        ovf_d  = (lost_s && (ovf_q != 16'hFFFF)) ? (ovf_q + 16'd1) : ovf_q;
    end

    // Control and output state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            meta_q   <= {META_LEN{1'b0}};
            ovf_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            meta_q   <= meta_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array carries no reset; pointers and level define what is live
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= comp_meta_data_in;
        end
    end

`ifdef META_DISCARD_FILTER_EN
    logic [15:0] drop_q, drop_d;

    // Saturating count of discard-flagged inputs
    always_comb begin
        if (comp_meta_data_valid_in && discard_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

    assign meta_out       = meta_q;
    assign meta_valid_out = (state_q == ST_VALID);
    assign fifo_level     = level_q;
    assign ovf_cnt        = ovf_q;

endmodule

// File: tb/tb_meta_out_dispatch.sv
// Self-checking bench for meta_out_dispatch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_meta_out_dispatch;

    localparam int ML = 256;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [ML-1:0] din;
    logic          vin;
    logic [ML-1:0] mout;
    logic          mvalid;
    logic          ready;
    logic [LW-1:0] level;
    logic [15:0]   ovf;
    logic [15:0]   drop;

    always #5 clk = ~clk;

    meta_out_dispatch #(.META_LEN(ML), .FIFO_DEPTH(D), .STAGE_ID(0)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .comp_meta_data_in       (din),
        .comp_meta_data_valid_in (vin),
        .meta_out                (mout),
        .meta_valid_out          (mvalid),
        .meta_ready_in           (ready),
        .fifo_level              (level),
        .ovf_cnt                 (ovf),
        .drop_cnt                (drop)
    );

    int checks   = 0;
    int errors   = 0;
    int n_accept = 0;

    // Reference model state
    logic [ML-1:0] q[$];
    bit            m_valid;
    logic [ML-1:0] m_out;
    int            m_ovf;
    int            m_drop;

    task automatic check_val(input string tag, input logic [ML-1:0] obs, input logic [ML-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        int lvl = q.size();
        bit pop = (lvl > 0) && (!m_valid || ready);
        bit filt;
`ifdef META_DISCARD_FILTER_EN
        filt = din[128];
`else
        filt = 1'b0;
`endif
        if (pop) begin
            m_out   = q.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (vin) begin
            if (filt) begin
                if (m_drop < 65535) m_drop++;
            end else if ((lvl < D) || pop) begin
                q.push_back(din);
            end else if (m_ovf < 65535) begin
                m_ovf++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_valid"}, ML'(mvalid), ML'(m_valid));
        check_val({tag, "_meta"},  mout, m_out);
        check_val({tag, "_level"}, ML'(level), ML'(q.size()));
        check_val({tag, "_ovf"},   ML'(ovf), ML'(m_ovf));
        check_val({tag, "_drop"},  ML'(drop), ML'(m_drop));
    endtask

    task automatic step(input logic v, input logic [ML-1:0] d, input logic r, input string tag);
        vin   = v;
        din   = d;
        ready = r;
        if (mvalid && r && !rst) n_accept++;
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all(tag);
    endtask

    function automatic logic [ML-1:0] mk(input logic [7:0] port, input logic disc);
        logic [ML-1:0] d;
        for (int i = 0; i < ML / 32; i++) d[i*32 +: 32] = $urandom;
        d[31:24] = port;
        d[128]   = disc;
        return d;
    endfunction

    logic [ML-1:0] e [5];
    logic [ML-1:0] tmp;
    int            acc_base;
    int            exp_acc;
    int            exp_drop;

    initial begin
        rst   = 1'b1;
        vin   = 1'b0;
        din   = '0;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // Single entry with downstream ready: one-cycle valid pulse two edges later
        tmp = mk(8'hAB, 1'b0);
        step(1'b1, tmp, 1'b1, "t026_a");
        check_val("t026_lat0", ML'(mvalid), ML'(1'b0));
        step(1'b0, '0, 1'b1, "t026_b");
        check_val("t026_lat1", ML'(mvalid), ML'(1'b1));
        check_val("t026_port", ML'(mout[31:24]), ML'(8'hAB));
        step(1'b0, '0, 1'b1, "t026_c");
        check_val("t026_pulse", ML'(mvalid), ML'(1'b0));

        // Fill with downstream stalled, then overflow, then drain in order
        for (int i = 0; i < 5; i++) begin
            e[i] = mk(8'(i + 1), 1'b0);
            step(1'b1, e[i], 1'b0, "t027_fill");
        end
        check_val("t027_level", ML'(level), ML'(3'd4));
        check_val("t027_valid", ML'(mvalid), ML'(1'b1));
        check_val("t027_head", mout, e[0]);
        check_val("t027_ovf", ML'(ovf), ML'(16'd0));
        step(1'b1, mk(8'hEE, 1'b0), 1'b0, "t028_lost");
        check_val("t028_ovf", ML'(ovf), ML'(16'd1));
        check_val("t028_level", ML'(level), ML'(3'd4));
        for (int i = 1; i < 5; i++) begin
            step(1'b0, '0, 1'b1, "t028_drain");
            check_val("t028_order", mout, e[i]);
            check_val("t028_b2b", ML'(mvalid), ML'(1'b1));
        end
        step(1'b0, '0, 1'b1, "t028_idle");
        check_val("t028_end", ML'(mvalid), ML'(1'b0));

        // Alternating discard flag over six inputs
        acc_base = n_accept;
        exp_drop = int'(drop);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(8'(8'h40 + i), ((i % 2) == 0) ? 1'b1 : 1'b0), 1'b1, "t029_in");
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "t029_drain");
`ifdef META_DISCARD_FILTER_EN
        exp_acc  = 3;
        exp_drop = exp_drop + 3;
`else
        exp_acc  = 6;
`endif
        check_val("t029_drop", ML'(drop), ML'(exp_drop));
        check_val("t029_outputs", ML'(n_accept - acc_base), ML'(exp_acc));

        // Randomized traffic with backpressure
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 mk(8'($urandom), 1'($urandom)),
                 1'($urandom),
                 "rand");
        end

        // Mid-stream asynchronous reset
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "t030_drain");
        for (int i = 0; i < 4; i++) step(1'b1, mk(8'(8'h60 + i), 1'b0), 1'b0, "t030_fill");
        check_val("t030_pre_level", ML'(level), ML'(3'd3));
        check_val("t030_pre_valid", ML'(mvalid), ML'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("t030_async");
        step(1'b1, mk(8'h77, 1'b0), 1'b1, "t030_inrst");
        rst = 1'b0;
        tmp = mk(8'h5A, 1'b0);
        step(1'b1, tmp, 1'b0, "t030_post_a");
        check_val("t030_post_lat0", ML'(mvalid), ML'(1'b0));
        step(1'b0, '0, 1'b0, "t030_post_b");
        check_val("t030_post_valid", ML'(mvalid), ML'(1'b1));
        check_val("t030_post_data", mout, tmp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
